// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state encoding, floor index width and call-search helpers
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  // Zero-based floor index; 3 bits covers up to 8 floors.
  localparam int FLOOR_W = 3;

  // Any latched call strictly above the given zero-based floor index.
  function automatic logic calls_above(input logic [7:0] calls, input logic [FLOOR_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (calls[k] && (k > int'(idx))) r = 1'b1;
    end
    return r;
  endfunction

  // Any latched call strictly below the given zero-based floor index.
  function automatic logic calls_below(input logic [7:0] calls, input logic [FLOOR_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (calls[k] && (k < int'(idx))) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// rtl/elev_timer.sv - loadable down-counter with enable and zero flag
module elev_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN call scheduler and motion/door sequencer; DOOR_EXTEND_EN lets B[cur] hold the door open
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS        = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [FLOORS:1]   B,
  output logic [FLOORS:1]   O,
  output logic [FLOORS:1]   pend,
  output logic              motor_up,
  output logic              motor_dn,
  output logic              door_open,
  output logic              dir_up
);

  localparam int TW = 16;

  state_t               state, state_n;
  logic [FLOOR_W-1:0]   fidx, fidx_n;
  logic [FLOORS-1:0]    pend_r, pend_n, clr;
  logic [FLOORS-1:0]    onehot, up_mask, dn_mask;
  logic [7:0]           pend8;
  logic                 dir_r, dir_n;
  logic                 above, below;
  logic                 tr_load, tr_en, tr_zero;
  logic                 dr_load, dr_en, dr_zero;

  // Car position as a one-hot mask, plus masks of the neighbouring floors.
  assign onehot  = {{(FLOORS-1){1'b0}}, 1'b1} << fidx;
  assign up_mask = onehot << 1;
  assign dn_mask = onehot >> 1;

  // Pad pending calls to the helper width for the direction search.
  always_comb begin
    pend8 = '0;
    pend8[FLOORS-1:0] = pend_r;
  end

  assign above = calls_above(pend8, fidx);
  assign below = calls_below(pend8, fidx);

  elev_timer #(.W(TW)) u_travel (
    .clk      (clk),
    .rst      (RESET),
    .load     (tr_load),
    .en       (tr_en),
    .load_val (TW'(TRAVEL_CYCLES - 1)),
    .zero     (tr_zero)
  );

  elev_timer #(.W(TW)) u_door (
    .clk      (clk),
    .rst      (RESET),
    .load     (dr_load),
    .en       (dr_en),
    .load_val (TW'(DOOR_CYCLES - 1)),
    .zero     (dr_zero)
  );

  // Next state, floor step, direction, timer control and call clearing.
  always_comb begin
    state_n = state;
    fidx_n  = fidx;
    dir_n   = dir_r;
    clr     = '0;
    tr_load = 1'b0;
    tr_en   = 1'b0;
    dr_load = 1'b0;
    dr_en   = 1'b0;
    case (state)
      IDLE: begin
        if ((pend_r & onehot) != '0) begin
          state_n = DOOR;
          dr_load = 1'b1;
          clr     = onehot;
        end else if (above && (dir_r || !below)) begin
          state_n = MOVE_UP;
          dir_n   = 1'b1;
          tr_load = 1'b1;
        end else if (below) begin
          state_n = MOVE_DN;
          dir_n   = 1'b0;
          tr_load = 1'b1;
        end
      end
      MOVE_UP: begin
        if (tr_zero) begin
          fidx_n = fidx + FLOOR_W'(1);
          if ((pend_r & up_mask) != '0) begin
            state_n = DOOR;
            dr_load = 1'b1;
            clr     = up_mask;
          end else if (calls_above(pend8, fidx_n)) begin
            tr_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tr_en = 1'b1;
        end
      end
      MOVE_DN: begin
        if (tr_zero) begin
          fidx_n = fidx - FLOOR_W'(1);
          if ((pend_r & dn_mask) != '0) begin
            state_n = DOOR;
            dr_load = 1'b1;
            clr     = dn_mask;
          end else if (calls_below(pend8, fidx_n)) begin
            tr_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tr_en = 1'b1;
        end
      end
      DOOR: begin
        // The call at the open floor stays cleared while the door is open.
        clr = onehot;
`ifdef DOOR_EXTEND_EN
        if ((B & onehot) != '0) begin
          dr_load = 1'b1;
        end else if (dr_zero) begin
          state_n = IDLE;
        end else begin
          dr_en = 1'b1;
        end
`else
        if (dr_zero) begin
          state_n = IDLE;
        end else begin
          dr_en = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    // Clearing the served floor wins over a simultaneous press there.
    pend_n = (pend_r | B) & ~clr;
  end

  // State, position, direction and call latch registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      fidx   <= '0;
      pend_r <= '0;
      dir_r  <= 1'b1;
    end else begin
      state  <= state_n;
      fidx   <= fidx_n;
      pend_r <= pend_n;
      dir_r  <= dir_n;
    end
  end

  assign O         = onehot;
  assign pend      = pend_r;
  assign dir_up    = dir_r;
  assign motor_up  = (state == MOVE_UP);
  assign motor_dn  = (state == MOVE_DN);
  assign door_open = (state == DOOR);

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Request scheduler and motion/door sequencer for the elevator car. Latches hall/car button calls per floor and models the car position. Serves calls in collective (SCAN) order, driving motor-up/down and door-open outputs with cycle-counted travel and dwell times. Sits between the raw button inputs and the floor-indicator outputs, replacing ad-hoc next-state logic with a sequenced controller.

Parameters:
FLOORS, 3, number of floors served; floors numbered 1..FLOORS; legal range 2..8.
TRAVEL_CYCLES, 4, clock cycles spent moving between adjacent floors; minimum 1.
DOOR_CYCLES, 3, clock cycles the door stays open per stop; minimum 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
B  in  [FLOORS:1]  level call buttons, one per floor; sampled every clock.
O  out  [FLOORS:1]  one-hot current floor indicator.
pend  out  [FLOORS:1]  latched outstanding calls.
motor_up  out  1  car moving up.
motor_dn  out  1  car moving down.
door_open  out  1  door open at the current floor.
dir_up  out  1  current service direction; 1 = up.

Behaviour:
- Reset (asynchronous, immediate, including mid-move or door open):
  - state=IDLE, floor=1, O=1 (one-hot floor 1), pend=0, dir_up=1.
  - motor_up=motor_dn=door_open=0; both timers cleared.
- States are IDLE, MOVE_UP, MOVE_DN, DOOR.
  - motor_up=(state==MOVE_UP); motor_dn=(state==MOVE_DN); door_open=(state==DOOR).
  - All outputs are decoded from registers; motor_up and motor_dn are never both 1.
- Call latching: pend[i] sets on the edge after B[i]=1. It clears on the edge entering DOOR at floor i. In DOOR, pend[cur] is held 0; clear wins over set.
- Direction preference: "above" = any pend bit with index > cur; "below" = any with index < cur.
- IDLE decisions, evaluated with registered pend:
  - pend[cur] -> DOOR.
  - else above and (dir_up or no below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DN, dir_up=0.
  - else stay IDLE.
- MOVE_x:
  - Travel timer loads TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - At timer==0 the next edge steps floor by ±1 (O updates the same edge).
  - Then: pend[new floor] -> DOOR; else more calls in the same direction -> reload timer and continue; else -> IDLE.
  - Each floor step takes exactly TRAVEL_CYCLES cycles.
- DOOR: door timer loads DOOR_CYCLES-1 on entry; the door is open exactly DOOR_CYCLES cycles, then -> IDLE.
- Boundaries:
  - floor never exceeds FLOORS or goes below 1.
  - MOVE_UP is never entered at FLOORS; MOVE_DN is never entered at 1.
  - At the top or bottom floor, direction reverses only via IDLE.
- Simultaneous events:
  - Calls above and below in IDLE -> continue dir_up.
  - Calls arriving during a move are honoured if the car has not yet passed the floor; otherwise they are served on the return sweep.
- Latency: with the car idle at floor 1, B[1] at cycle 0 -> pend[1] at edge 1 -> door_open at edge 2.

Optional Feature:
DOOR_EXTEND_EN:
- Defined: B[cur]=1 while in DOOR reloads the door timer to DOOR_CYCLES-1, so the door stays open until DOOR_CYCLES cycles after the last press.
- Undefined: B[cur] during DOOR is ignored; the dwell time is fixed.

Decomposition:
- Shared package elevator_pkg holds:
  - state encoding localparams: IDLE=2'd0, MOVE_UP=2'd1, MOVE_DN=2'd2, DOOR=2'd3;
  - the floor-index width constant (3 bits, sufficient for up to 8 floors).
- One sub-module is natural: elev_timer, a loadable down-counter with load, enable and zero flag. It is instantiated twice, once for travel and once for door dwell.

Test Plan:
- Reset then B=3'b100 for one cycle (defaults) -> pend=100; motor_up high for 8 cycles; O 001->010->100; door_open 3 cycles; pend=000; IDLE.
- Car at floor 3 in IDLE; B=3'b011 -> moves down, stops at floor 2 (door 3 cycles, pend=001), then floor 1, then IDLE with dir_up=0.
- Car at floor 1 moving up toward 3; B[2] pulsed during the first travel cycle -> stops at floor 2 first, then continues to 3.
- Car at floor 2 in IDLE; B=3'b101 same cycle -> goes up first (dir_up=1), serves 3, then 1.
- RESET asserted mid-MOVE_UP -> immediately O=001, motor_up=0, pend=000, no clock needed.
- B[cur] held during DOOR: with DOOR_EXTEND_EN the door stays open until 3 cycles after release; without it the door closes after exactly 3 cycles.
